fft_frame_loader: RTL

- Input staging stage directly upstream of the FFT controller/IOBUF path.
- Accepts a 256-point complex frame one sample per cycle over a valid/ready stream.
- Reorders the frame into four lane-strided banks, then issues a one-cycle START to the FFT core.
- Streams 4 samples per cycle for exactly 64 cycles, aligned to the core's input phase, where the IOBUF write path consumes them.

---
 rtl/fft_frame_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// Input staging for the FFT core: buffers a 256-point frame into four lane-strided banks,
// pulses START and streams 4 samples/beat for 64 beats. Define LOADER_PINGPONG_EN for a second frame buffer.
module fft_frame_loader #(
    parameter int unsigned DW  = 32,
    parameter int unsigned NPT = 256
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    input  logic          CORE_IDLE,
    output logic          START,
    output logic          DVALID,
    output logic [DW-1:0] DOUT0,
    output logic [DW-1:0] DOUT1,
    output logic [DW-1:0] DOUT2,
    output logic [DW-1:0] DOUT3,
    output logic          FRAME_RDY
);

`ifdef LOADER_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    localparam int unsigned NLANE = 4;
    localparam int unsigned NBEAT = NPT / NLANE;
    localparam int unsigned WW    = $clog2(NPT);
    localparam int unsigned AW    = $clog2(NBEAT);
    localparam int unsigned LW    = $clog2(NLANE);
    localparam int unsigned NBUF  = PINGPONG ? 2 : 1;
    localparam int unsigned NBANK = NBUF * NLANE;
    localparam int unsigned BSW   = $clog2(NBANK);

    typedef enum logic [1:0] {FILL, ARM, KICK, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [AW-1:0]   rcnt_q, rcnt_d, raddr;
    logic            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]      full_q, full_d, iss_q, iss_d;
    logic            accept, load_beat, clr_out;
    logic            s_ready_q, start_q, dvalid_q, frame_rdy_q;
    logic [DW-1:0]   dout_q [NLANE];
    logic [DW-1:0]   mem [NBANK][NBEAT];

    assign accept = S_VALID & s_ready_q;

    // Write side fills the buffer at wptr; read side FSM issues the buffer at rptr.
    // full = frame stored and not yet drained, iss = frame already kicked to the core.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        full_d    = full_q;
        iss_d     = iss_q;
        raddr     = '0;
        load_beat = 1'b0;
        clr_out   = 1'b0;

        if (accept) begin
            wcnt_d = wcnt_q + WW'(1);
            if (wcnt_q == WW'(NPT - 1)) begin
                full_d[wptr_q] = 1'b1;
                wptr_d         = PINGPONG ? ~wptr_q : wptr_q;
            end
        end

        unique case (state_q)
            FILL: begin
                if (full_d[rptr_q]) state_d = ARM;
            end
            ARM: begin
                if (CORE_IDLE) state_d = KICK;
            end
            KICK: begin
                iss_d[rptr_q] = 1'b1;
                load_beat     = 1'b1;
                state_d       = DRAIN;
            end
            DRAIN: begin
                rcnt_d = rcnt_q + AW'(1);
                if (rcnt_q == AW'(NBEAT - 1)) begin
                    clr_out        = 1'b1;
                    full_d[rptr_q] = 1'b0;
                    iss_d[rptr_q]  = 1'b0;
                    rptr_d         = PINGPONG ? ~rptr_q : rptr_q;
                    state_d        = FILL;
                end else begin
                    load_beat = 1'b1;
                    raddr     = rcnt_q + AW'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            full_q      <= '0;
            iss_q       <= '0;
            s_ready_q   <= 1'b0;
            start_q     <= 1'b0;
            frame_rdy_q <= 1'b0;
            dvalid_q    <= 1'b0;
            for (int k = 0; k < NLANE; k++) dout_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            full_q      <= full_d;
            iss_q       <= iss_d;
            s_ready_q   <= ~full_d[wptr_d];
            start_q     <= (state_d == KICK);
            frame_rdy_q <= |(full_d & ~iss_d);
            if (load_beat) begin
                dvalid_q <= 1'b1;
                for (int k = 0; k < NLANE; k++)
                    dout_q[k] <= mem[BSW'({rptr_q, LW'(k)})][raddr];
            end else if (clr_out) begin
                dvalid_q <= 1'b0;
                for (int k = 0; k < NLANE; k++) dout_q[k] <= '0;
            end
        end
    end

    // Sample n lands in lane bank n[7:6] at address n[5:0]; storage needs no reset.
    always_ff @(posedge CLK) begin
        if (accept)
            mem[BSW'({wptr_q, wcnt_q[WW-1:AW]})][wcnt_q[AW-1:0]] <= S_DATA;
    end

    assign S_READY   = s_ready_q;
    assign START     = start_q;
    assign DVALID    = dvalid_q;
    assign FRAME_RDY = frame_rdy_q;
    assign DOUT0     = dout_q[0];
    assign DOUT1     = dout_q[1];
    assign DOUT2     = dout_q[2];
    assign DOUT3     = dout_q[3];

endmodule
